// File: rtl/decoder4to16_mux161_if.sv
// Bus bundle for the register-bank decode/select block: write-address decode
// and sixteen-way read select, with the block as slave and the bank/datapath as master.
interface decoder4to16_mux161_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       in;
    logic             en;
    logic [15:0]      out;
    logic [3:0]       select;
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;
    logic [WIDTH-1:0] q3;
    logic [WIDTH-1:0] q4;
    logic [WIDTH-1:0] q5;
    logic [WIDTH-1:0] q6;
    logic [WIDTH-1:0] q7;
    logic [WIDTH-1:0] q8;
    logic [WIDTH-1:0] q9;
    logic [WIDTH-1:0] q10;
    logic [WIDTH-1:0] q11;
    logic [WIDTH-1:0] q12;
    logic [WIDTH-1:0] q13;
    logic [WIDTH-1:0] q14;
    logic [WIDTH-1:0] q15;
    logic [WIDTH-1:0] mux_out;

    modport master (
        output in, en, select,
        output q0, q1, q2, q3, q4, q5, q6, q7,
        output q8, q9, q10, q11, q12, q13, q14, q15,
        input  out, mux_out
    );

    modport slave (
        input  in, en, select,
        input  q0, q1, q2, q3, q4, q5, q6, q7,
        input  q8, q9, q10, q11, q12, q13, q14, q15,
        output out, mux_out
    );
endinterface

// File: rtl/decoder4to16_mux161.sv
// Registered write-strobe decoder and 16:1 read-port select for the register bank.
// Both paths are independent and have exactly one cycle of latency.
module decoder4to16_mux161 #(
    parameter int WIDTH = 32
) (
    input logic                  clk,
    input logic                  reset,
    decoder4to16_mux161_if.slave bus
);

    logic [15:0]      decode_s;
    logic [WIDTH-1:0] mux_s;
    logic [15:0]      out_r;
    logic [WIDTH-1:0] mux_out_r;

    // Next-state one-hot write strobe; en low suppresses every strobe.
    always_comb begin
        decode_s = 16'h0000;
        if (bus.en) begin
            decode_s = 16'h0001 << bus.in;
        end else begin
            decode_s = 16'h0000;
        end
    end

    // Next-state read-port value; every select code maps to a register.
    always_comb begin
        mux_s = {WIDTH{1'b0}};
        case (bus.select)
            4'd0:    mux_s = bus.q0;
            4'd1:    mux_s = bus.q1;
            4'd2:    mux_s = bus.q2;
            4'd3:    mux_s = bus.q3;
            4'd4:    mux_s = bus.q4;
            4'd5:    mux_s = bus.q5;
            4'd6:    mux_s = bus.q6;
            4'd7:    mux_s = bus.q7;
            4'd8:    mux_s = bus.q8;
            4'd9:    mux_s = bus.q9;
            4'd10:   mux_s = bus.q10;
            4'd11:   mux_s = bus.q11;
            4'd12:   mux_s = bus.q12;
            4'd13:   mux_s = bus.q13;
            4'd14:   mux_s = bus.q14;
            4'd15:   mux_s = bus.q15;
            default: mux_s = {WIDTH{1'b0}};
        endcase
    end

    // Output registers; reset overrides every data input on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r     <= 16'h0000;
            mux_out_r <= {WIDTH{1'b0}};
        end else begin
            out_r     <= decode_s;
            mux_out_r <= mux_s;
        end
    end

    assign bus.out     = out_r;
    assign bus.mux_out = mux_out_r;

endmodule

// File: tb/tb_decoder4to16_mux161.sv
// Scoreboard bench for decoder4to16_mux161: expectations are queued when inputs
// are applied and compared one clock later against the registered outputs.
module tb_decoder4to16_mux161;

    typedef struct {
        logic [15:0] out;
        logic [31:0] mux;
        int          ones;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] qv [16];
    exp_t        sb [$];
    int          checks = 0;
    int          failures = 0;

    decoder4to16_mux161_if #(.WIDTH(32)) bus ();

    decoder4to16_mux161 #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.q0  = qv[0];
    assign bus.q1  = qv[1];
    assign bus.q2  = qv[2];
    assign bus.q3  = qv[3];
    assign bus.q4  = qv[4];
    assign bus.q5  = qv[5];
    assign bus.q6  = qv[6];
    assign bus.q7  = qv[7];
    assign bus.q8  = qv[8];
    assign bus.q9  = qv[9];
    assign bus.q10 = qv[10];
    assign bus.q11 = qv[11];
    assign bus.q12 = qv[12];
    assign bus.q13 = qv[13];
    assign bus.q14 = qv[14];
    assign bus.q15 = qv[15];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: one-hot built bit by bit, mux read from the bench's own array.
    function automatic exp_t model();
        exp_t e;
        e.out  = 16'h0000;
        e.mux  = 32'h0;
        e.ones = 0;
        if (!reset) begin
            if (bus.en) begin
                for (int i = 0; i < 16; i++) e.out[i] = (bus.in == i[3:0]);
                e.ones = 1;
            end
            e.mux = qv[bus.select];
        end
        return e;
    endfunction

    task automatic cycle(input string tag);
        exp_t e;
        sb.push_back(model());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq({tag, ".out"}, {16'h0000, bus.out}, {16'h0000, e.out});
        check_eq({tag, ".mux"}, bus.mux_out, e.mux);
        check_eq({tag, ".ones"}, $countones(bus.out), e.ones);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) qv[i] = 32'h0;
        bus.in = 4'd5;
        bus.en = 1'b1;
        bus.select = 4'd3;
        qv[3] = 32'hDEADBEEF;

        // Reset priority, then first valid output.
        reset = 1'b1;
        cycle("reset");
        check_eq("reset.abs_out", {16'h0000, bus.out}, 32'h0000_0000);
        check_eq("reset.abs_mux", bus.mux_out, 32'h0);
        reset = 1'b0;
        cycle("release");
        check_eq("release.abs_out", {16'h0000, bus.out}, 32'h0000_0020);
        check_eq("release.abs_mux", bus.mux_out, 32'hDEADBEEF);

        // Decoder sweep across all sixteen codes.
        for (int a = 0; a < 16; a++) begin
            bus.in = a[3:0];
            bus.en = 1'b1;
            cycle("dec_sweep");
        end
        check_eq("dec_sweep.last", {16'h0000, bus.out}, 32'h0000_8000);

        // Enable toggling on a fixed address.
        bus.in = 4'd7;
        bus.en = 1'b1; cycle("dis_on1");
        bus.en = 1'b0; cycle("dis_off");
        bus.en = 1'b1; cycle("dis_on2");

        // Mux sweep with a one-cycle reset at select 12.
        for (int n = 0; n < 16; n++) qv[n] = 32'h1000_0000 + n;
        for (int s = 0; s < 16; s++) begin
            bus.select = s[3:0];
            bus.in = s[3:0];
            reset = (s == 12);
            cycle("mux_sweep");
        end
        reset = 1'b0;
        check_eq("mux_sweep.last", bus.mux_out, 32'h1000_000F);

        // q9 tracking while neighbours churn.
        bus.select = 4'd9;
        bus.en = 1'b0;
        qv[9] = 32'h0;         qv[8] = 32'h1111_1111; qv[10] = 32'h2222_2222; cycle("trk0");
        qv[9] = 32'hFFFFFFFF;  qv[8] = 32'h3333_3333; qv[10] = 32'h4444_4444; cycle("trk1");
        qv[9] = 32'hA5A5A5A5;  qv[8] = 32'h5555_5555; qv[10] = 32'h6666_6666; cycle("trk2");
        check_eq("trk.abs", bus.mux_out, 32'hA5A5A5A5);

        // Random back-to-back traffic on both paths.
        for (int r = 0; r < 40; r++) begin
            bus.in = 4'($urandom_range(0, 15));
            bus.en = 1'($urandom_range(0, 1));
            bus.select = 4'($urandom_range(0, 15));
            qv[$urandom_range(0, 15)] = $urandom;
            reset = ($urandom_range(0, 9) == 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder4to16_mux161.md
# decoder4to16_mux161

Registered address-decode and read-select block for the 16-entry, 32-bit register bank. It turns a 4-bit write address into a one-hot write-strobe vector. It also selects one of sixteen 32-bit register values onto a single read port. Two instances of the select path, or one block per read port, feed the ALU source operands; the decode path drives the bank's write enables.

## Interface
Parameters:
- WIDTH, 32, data width of each mux input and of the mux output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- in  input  4  decoder address (destination register number).
- en  input  1  decoder enable; when low, no strobe is produced (used to suppress writes, e.g. for non-writing opcodes).
- out  output  16  registered one-hot decode of `in`.
- select  input  4  mux select (source register number).
- q0 … q15  input  WIDTH each  mux data inputs; q<n> is register n.
- mux_out  output  WIDTH  registered value of q[select].

## Operation
- Decoder, evaluated each cycle:
  - en=1: next out = 16'b1 << in. Exactly one bit is set, at bit position `in`.
  - en=0: next out = 16'h0000.
  - in=0 sets bit 0; in=15 sets bit 15. There are no invalid codes.
- Mux, evaluated each cycle:
  - next mux_out = q[select], selected from q0…q15.
  - All 16 select codes are valid; there is no default or undefined output.
  - The width is carried unchanged, with no extension or truncation.
- The decode path and the mux path are fully independent. A change on one never affects the other.
- Both paths update every cycle. There is no hold state; the outputs track the inputs with a delay of one cycle.
- There is no arithmetic inside the block.

## Timing
- Latency on both paths is exactly 1 clock. Inputs sampled at edge N appear on the outputs after edge N, and hold until edge N+1.
- Reset:
  - When reset=1 at a rising edge, out=16'h0000 and mux_out=0, regardless of the other inputs.
  - Reset has priority over en, in, select and q*.
- Reset mid-operation: the output clears on that edge. The first valid output appears on the first edge at which reset=0.
- There is no handshake. Inputs must be stable across the setup/hold window around clk.
- Simultaneous changes on in, en, select and q* within one cycle are all captured on the same edge.
- Before the first reset, output values are undefined. Verification starts after one reset cycle.
- Back-to-back operation:
  - A new address or select may be applied every cycle.
  - Full throughput is one result per cycle per path.

## Test plan
- **Reset:** hold reset=1 with in=5, en=1, select=3, q3=32'hDEADBEEF. After the edge, out=16'h0000 and mux_out=32'h0. Release reset; the next edge gives out=16'h0020 and mux_out=32'hDEADBEEF.
- **Decoder sweep:** en=1, in=0…15 on successive cycles. One cycle later out is 16'h0001, 16'h0002, … 16'h8000. Check the one-hot property ($countones==1) every cycle.
- **Decoder disable:** in=7 with en toggling 1,0,1. out is 16'h0080, 16'h0000, 16'h0080 with 1-cycle lag.
- **Mux sweep:** load q<n>=32'h1000_0000+n. Step select 0…15; mux_out is 32'h1000_0000…32'h1000_000F one cycle later.
- **Data-change tracking:** select=9 held; change q9 from 32'h0 to 32'hFFFFFFFF to 32'hA5A5A5A5 on consecutive cycles. mux_out follows with exactly one cycle lag. Changes on q8 and q10 have no effect.
- **Mid-stream reset:** during the mux sweep at select=12, assert reset for one cycle. That cycle's outputs are 0; the sweep resumes correctly on the following cycle with no stale value.
